stage_exe: RTL and testbench
============================

STAGE_EXE -- requirements
Module: stage_exe

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 data_a  in  32  ALU operand A (rs value).
REQ-004 data_b  in  32  rt value; ALU operand B when control_use_b=1; store data.
REQ-005 data_imm  in  32  sign-extended immediate; [5:0]=funct, [10:6]=shamt for R-type.
REQ-006 control_oper  in  4  ALU operation class (REQ-021).
REQ-007 control_use_b  in  1  1: operand B=data_b; 0: operand B=immediate.
REQ-008 control_Reg_DST  in  1  1: destination=regaddr2 (rd); 0: regaddr1 (rt).
REQ-009 npc  in  32  next PC, word-addressed.
REQ-010 control_is_jump, control_branch_eq, control_branch_inc  in  1 each  branch/jump flags.
REQ-011 wbi  in  2  write-back control; M  in  1  memory control.
REQ-012 regaddr1, regaddr2  in  5 each  rt / rd register numbers.
REQ-013 is_jump_o, branch_eq_o, branch_inc_o  out  1 each  registered copies of the flags.
REQ-014 zero  out  1  registered (ALU result == 0).
REQ-015 jump_address  out  32  registered branch target.
REQ-016 wbi_o  out  2; M_o  out  1  registered pass-through.
REQ-017 regaddr_o  out  5  registered selected destination register.
REQ-018 data_b_o  out  32  registered data_b; out  out  32  registered ALU result.

Function
REQ-019 Every output SHALL be an EX/MEM pipeline register, updating on each rising clock edge; latency exactly one cycle; no stall/enable.
REQ-020 Operand B SHALL be data_b if control_use_b=1, else data_imm (zero-extended data_imm[15:0] for andi/ori/xori).
REQ-021 control_oper: 0000 add; 0001 sub; 0010 R-type via funct; 1000 addi; 1001 addiu; 1010 slti; 1011 sltiu; 1100 andi; 1101 ori; 1110 xori; 1111 lui (data_imm[15:0]<<16); other codes add.
REQ-022 R-type funct: 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt signed, 0x2B sltu unsigned, 0x00 sll, 0x02 srl, 0x03 sra (shamt), 0x04 sllv, 0x06 srlv, 0x07 srav (data_a[4:0]); other funct yields 0.
REQ-023 Arithmetic SHALL be 32-bit modulo 2^32; no overflow detection or trap.
REQ-024 slt/slti result SHALL be 1 or 0 in bit 0, upper bits zero.
REQ-025 zero SHALL be 1 exactly when the result registered into out is 0.
REQ-026 jump_address SHALL be npc + data_imm (32-bit, wrap-around, no shift; PC word-addressed).
REQ-027 regaddr_o = control_Reg_DST ? regaddr2 : regaddr1.
REQ-028 Branch-taken decisions SHALL NOT be made here; flags and zero are forwarded only.

Reset
REQ-029 While reset=1 at a rising edge, all outputs SHALL load 0 (zero=0 included), overriding inputs.
REQ-030 Reset asserted mid-stream SHALL discard the in-flight instruction; first valid output appears one edge after reset deasserts.

Structure
REQ-031 control_oper codes, funct codes and the 32-bit data width SHALL be constants in a shared MIPS package used also by decode/control.
REQ-032 ALU SHALL be one combinational sub-module, alu, (operands, control_oper, funct, shamt -> result); stage_exe holds muxes and pipeline register.

Verification
REQ-033 Reset 1 for two cycles, then 0 -> all outputs 0 during reset.
REQ-034 a=3, b=2, imm=0x20, oper=0010, use_b=1, npc=0 -> out=5, zero=0, jump_address=0x20 next edge.
REQ-035 a=3, b=2, imm=0x22, oper=0010, use_b=1, npc=1 -> out=1; then imm=1, oper=1000, use_b=0 -> out=4.
REQ-036 a=3, imm=1, oper=1100, use_b=0 -> out=1; imm=0xFFFF8000, oper=1101 -> out=0x8003.
REQ-037 a=3, b=3, imm=7, oper=0001, use_b=1, npc=4, control_branch_eq=1 -> out=0, zero=1, jump_address=11, branch_eq_o=1.
REQ-038 regaddr1=5, regaddr2=9, wbi=2, M=1, data_b=0xDEADBEEF: Reg_DST=1 -> regaddr_o=9; Reg_DST=0 -> 5; wbi_o=2, M_o=1, data_b_o=0xDEADBEEF; a=0x7FFFFFFF+1 via add -> out=0x80000000.

Source files
------------

// File: rtl/stage_exe_pkg.sv
// Shared MIPS constants: datapath width, EX operation classes and R-type
// function codes. Decode/control and the execute stage use the same values.
package stage_exe_pkg;

    localparam int DATA_W = 32;

    // ALU operation classes carried on control_oper
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_RTYPE = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b1000;
    localparam logic [3:0] OP_ADDIU = 4'b1001;
    localparam logic [3:0] OP_SLTI  = 4'b1010;
    localparam logic [3:0] OP_SLTIU = 4'b1011;
    localparam logic [3:0] OP_ANDI  = 4'b1100;
    localparam logic [3:0] OP_ORI   = 4'b1101;
    localparam logic [3:0] OP_XORI  = 4'b1110;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // R-type funct field values
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Logical immediates take the raw 16-bit field, not the sign-extended one
    function automatic logic uses_zero_ext_imm(input logic [3:0] oper);
        logic result;
        case (oper)
            OP_ANDI, OP_ORI, OP_XORI: result = 1'b1;
            default:                  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/stage_exe_alu.sv
// Combinational MIPS ALU: operation class plus funct/shamt for R-type.
// All arithmetic wraps modulo 2^32; no overflow detection.
module alu
    import stage_exe_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [3:0]        i_oper,
    input  logic [5:0]        i_funct,
    input  logic [4:0]        i_shamt,
    output logic [DATA_W-1:0] o_result
);

    logic [DATA_W-1:0] w_rtype_result;
    logic              w_lt_signed;
    logic              w_lt_unsigned;

    assign w_lt_signed   = ($signed(i_a) < $signed(i_b));
    assign w_lt_unsigned = (i_a < i_b);

    // R-type result selected by funct; unknown funct codes produce zero
    always_comb begin
        w_rtype_result = {DATA_W{1'b0}};
        case (i_funct)
            FN_ADD, FN_ADDU: w_rtype_result = i_a + i_b;
            FN_SUB, FN_SUBU: w_rtype_result = i_a - i_b;
            FN_AND:          w_rtype_result = i_a & i_b;
            FN_OR:           w_rtype_result = i_a | i_b;
            FN_XOR:          w_rtype_result = i_a ^ i_b;
            FN_NOR:          w_rtype_result = ~(i_a | i_b);
            FN_SLT:          w_rtype_result = {{(DATA_W-1){1'b0}}, w_lt_signed};
            FN_SLTU:         w_rtype_result = {{(DATA_W-1){1'b0}}, w_lt_unsigned};
            FN_SLL:          w_rtype_result = i_b << i_shamt;
            FN_SRL:          w_rtype_result = i_b >> i_shamt;
            FN_SRA:          w_rtype_result = $signed(i_b) >>> i_shamt;
            FN_SLLV:         w_rtype_result = i_b << i_a[4:0];
            FN_SRLV:         w_rtype_result = i_b >> i_a[4:0];
            FN_SRAV:         w_rtype_result = $signed(i_b) >>> i_a[4:0];
            default:         w_rtype_result = {DATA_W{1'b0}};
        endcase
    end

    // Top-level operation select; unlisted classes behave as add
    always_comb begin
        o_result = {DATA_W{1'b0}};
        case (i_oper)
            OP_ADD, OP_ADDI, OP_ADDIU: o_result = i_a + i_b;
            OP_SUB:                    o_result = i_a - i_b;
            OP_RTYPE:                  o_result = w_rtype_result;
            OP_SLTI:                   o_result = {{(DATA_W-1){1'b0}}, w_lt_signed};
            OP_SLTIU:                  o_result = {{(DATA_W-1){1'b0}}, w_lt_unsigned};
            OP_ANDI:                   o_result = i_a & i_b;
            OP_ORI:                    o_result = i_a | i_b;
            OP_XORI:                   o_result = i_a ^ i_b;
            OP_LUI:                    o_result = {i_b[15:0], 16'h0000};
            default:                   o_result = i_a + i_b;
        endcase
    end

endmodule

// File: rtl/stage_exe.sv
// MIPS execute stage: operand muxing, ALU, branch target adder and the
// EX/MEM pipeline register. Branch decisions are left to the next stage.
module stage_exe
    import stage_exe_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] data_imm,
    input  logic [3:0]        control_oper,
    input  logic              control_use_b,
    input  logic              control_Reg_DST,
    input  logic [DATA_W-1:0] npc,
    input  logic              control_is_jump,
    input  logic              control_branch_eq,
    input  logic              control_branch_inc,
    input  logic [1:0]        wbi,
    input  logic              M,
    input  logic [4:0]        regaddr1,
    input  logic [4:0]        regaddr2,
    output logic              is_jump_o,
    output logic              branch_eq_o,
    output logic              branch_inc_o,
    output logic              zero,
    output logic [DATA_W-1:0] jump_address,
    output logic [1:0]        wbi_o,
    output logic              M_o,
    output logic [4:0]        regaddr_o,
    output logic [DATA_W-1:0] data_b_o,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] w_operand_b;
    logic [DATA_W-1:0] w_alu_result;
    logic [DATA_W-1:0] w_jump_address;
    logic [4:0]        w_regaddr;

    // Operand B: register value, or immediate (zero-extended for logical ops)
    always_comb begin
        w_operand_b = data_imm;
        if (control_use_b) begin
            w_operand_b = data_b;
        end else if (uses_zero_ext_imm(control_oper)) begin
            w_operand_b = {16'h0000, data_imm[15:0]};
        end else begin
            w_operand_b = data_imm;
        end
    end

    // PC is word-addressed, so the offset is added without shifting
    assign w_jump_address = npc + data_imm;
    assign w_regaddr      = control_Reg_DST ? regaddr2 : regaddr1;

    alu u_alu (
        .i_a      (data_a),
        .i_b      (w_operand_b),
        .i_oper   (control_oper),
        .i_funct  (data_imm[5:0]),
        .i_shamt  (data_imm[10:6]),
        .o_result (w_alu_result)
    );

    // EX/MEM pipeline register; reset clears everything, including zero
    always_ff @(posedge clock) begin
        if (reset) begin
            is_jump_o    <= 1'b0;
            branch_eq_o  <= 1'b0;
            branch_inc_o <= 1'b0;
            zero         <= 1'b0;
            jump_address <= {DATA_W{1'b0}};
            wbi_o        <= 2'b00;
            M_o          <= 1'b0;
            regaddr_o    <= 5'd0;
            data_b_o     <= {DATA_W{1'b0}};
            out          <= {DATA_W{1'b0}};
        end else begin
            is_jump_o    <= control_is_jump;
            branch_eq_o  <= control_branch_eq;
            branch_inc_o <= control_branch_inc;
            zero         <= (w_alu_result == {DATA_W{1'b0}});
            jump_address <= w_jump_address;
            wbi_o        <= wbi;
            M_o          <= M;
            regaddr_o    <= w_regaddr;
            data_b_o     <= data_b;
            out          <= w_alu_result;
        end
    end

endmodule

// File: tb/tb_stage_exe.sv
// Directed self-checking bench for stage_exe.
module tb_stage_exe;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_a, data_b, data_imm, npc;
    logic [3:0]  control_oper;
    logic        control_use_b, control_Reg_DST;
    logic        control_is_jump, control_branch_eq, control_branch_inc;
    logic [1:0]  wbi;
    logic        M;
    logic [4:0]  regaddr1, regaddr2;
    logic        is_jump_o, branch_eq_o, branch_inc_o, zero, M_o;
    logic [31:0] jump_address, data_b_o, out;
    logic [1:0]  wbi_o;
    logic [4:0]  regaddr_o;

    int checks = 0;
    int failures = 0;

    stage_exe dut (
        .clock              (clock),
        .reset              (reset),
        .data_a             (data_a),
        .data_b             (data_b),
        .data_imm           (data_imm),
        .control_oper       (control_oper),
        .control_use_b      (control_use_b),
        .control_Reg_DST    (control_Reg_DST),
        .npc                (npc),
        .control_is_jump    (control_is_jump),
        .control_branch_eq  (control_branch_eq),
        .control_branch_inc (control_branch_inc),
        .wbi                (wbi),
        .M                  (M),
        .regaddr1           (regaddr1),
        .regaddr2           (regaddr2),
        .is_jump_o          (is_jump_o),
        .branch_eq_o        (branch_eq_o),
        .branch_inc_o       (branch_inc_o),
        .zero               (zero),
        .jump_address       (jump_address),
        .wbi_o              (wbi_o),
        .M_o                (M_o),
        .regaddr_o          (regaddr_o),
        .data_b_o           (data_b_o),
        .out                (out)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle before sampling
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_alu(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic [3:0] oper,
                             input logic use_b);
        data_a        = a;
        data_b        = b;
        data_imm      = imm;
        control_oper  = oper;
        control_use_b = use_b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_alu(32'd3, 32'hDEADBEEF, 32'd5, 4'b0000, 1'b1);
        npc = 32'd7; control_Reg_DST = 1'b1;
        control_is_jump = 1'b1; control_branch_eq = 1'b1; control_branch_inc = 1'b1;
        wbi = 2'd3; M = 1'b1; regaddr1 = 5'd5; regaddr2 = 5'd9;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out !== 32'd0 || zero !== 1'b0 || jump_address !== 32'd0 || data_b_o !== 32'd0) begin
                failures++;
                $display("FAIL reset_data cyc%0d: out=%h zero=%b jump=%h data_b_o=%h, expected all 0",
                         i, out, zero, jump_address, data_b_o);
            end
            checks++;
            if (is_jump_o !== 1'b0 || branch_eq_o !== 1'b0 || branch_inc_o !== 1'b0 ||
                wbi_o !== 2'd0 || M_o !== 1'b0 || regaddr_o !== 5'd0) begin
                failures++;
                $display("FAIL reset_ctrl cyc%0d: flags=%b%b%b wbi_o=%0d M_o=%b regaddr_o=%0d, expected all 0",
                         i, is_jump_o, branch_eq_o, branch_inc_o, wbi_o, M_o, regaddr_o);
            end
        end
        reset = 1'b0;
        control_is_jump = 1'b0; control_branch_eq = 1'b0; control_branch_inc = 1'b0;
        wbi = 2'd0; M = 1'b0;
    endtask

    task automatic test_rtype_add();
        drive_alu(32'd3, 32'd2, 32'h20, 4'b0010, 1'b1);
        npc = 32'd0;
        tick();
        checks++;
        if (out !== 32'd5 || zero !== 1'b0 || jump_address !== 32'h20) begin
            failures++;
            $display("FAIL rtype_add: out=%h zero=%b jump=%h, expected 5 0 20", out, zero, jump_address);
        end
    endtask

    task automatic test_sub_addi();
        drive_alu(32'd3, 32'd2, 32'h22, 4'b0010, 1'b1);
        npc = 32'd1;
        tick();
        checks++;
        if (out !== 32'd1 || jump_address !== 32'h23) begin
            failures++;
            $display("FAIL rtype_sub: out=%h jump=%h, expected 1 23", out, jump_address);
        end
        drive_alu(32'd3, 32'd2, 32'd1, 4'b1000, 1'b0);
        tick();
        checks++;
        if (out !== 32'd4 || jump_address !== 32'd2) begin
            failures++;
            $display("FAIL addi: out=%h jump=%h, expected 4 2", out, jump_address);
        end
    endtask

    task automatic test_logical_imm();
        logic [31:0] a_v   [5] = '{32'd3, 32'd3, 32'h000000FF, 32'hFFFFFFFF, 32'd0};
        logic [31:0] imm_v [5] = '{32'd1, 32'hFFFF8000, 32'hFFFF000F, 32'hFFFF8000, 32'h00001234};
        logic [3:0]  op_v  [5] = '{4'b1100, 4'b1101, 4'b1110, 4'b1100, 4'b1111};
        logic [31:0] exp_v [5] = '{32'd1, 32'h00008003, 32'h000000F0, 32'h00008000, 32'h12340000};
        for (int i = 0; i < 5; i++) begin
            drive_alu(a_v[i], 32'hAAAAAAAA, imm_v[i], op_v[i], 1'b0);
            tick();
            checks++;
            if (out !== exp_v[i]) begin
                failures++;
                $display("FAIL logical_imm[%0d]: out=%h expected %h", i, out, exp_v[i]);
            end
        end
    endtask

    task automatic test_branch();
        drive_alu(32'd3, 32'd3, 32'd7, 4'b0001, 1'b1);
        npc = 32'd4; control_branch_eq = 1'b1;
        tick();
        checks++;
        if (out !== 32'd0 || zero !== 1'b1 || jump_address !== 32'd11 ||
            branch_eq_o !== 1'b1 || is_jump_o !== 1'b0 || branch_inc_o !== 1'b0) begin
            failures++;
            $display("FAIL branch_eq: out=%h zero=%b jump=%h flags(j,eq,inc)=%b%b%b, expected 0 1 b 010",
                     out, zero, jump_address, is_jump_o, branch_eq_o, branch_inc_o);
        end
        control_branch_eq = 1'b0; control_is_jump = 1'b1; control_branch_inc = 1'b1;
        npc = 32'hFFFFFFFF; data_imm = 32'd2;
        tick();
        checks++;
        if (jump_address !== 32'd1 || is_jump_o !== 1'b1 || branch_eq_o !== 1'b0 || branch_inc_o !== 1'b1) begin
            failures++;
            $display("FAIL jump_wrap: jump=%h flags(j,eq,inc)=%b%b%b, expected 1 101",
                     jump_address, is_jump_o, branch_eq_o, branch_inc_o);
        end
        control_is_jump = 1'b0; control_branch_inc = 1'b0;
    endtask

    task automatic test_passthrough();
        regaddr1 = 5'd5; regaddr2 = 5'd9; wbi = 2'd2; M = 1'b1; control_Reg_DST = 1'b1;
        drive_alu(32'h7FFFFFFF, 32'hDEADBEEF, 32'd1, 4'b0000, 1'b0);
        npc = 32'd0;
        tick();
        checks++;
        if (regaddr_o !== 5'd9 || wbi_o !== 2'd2 || M_o !== 1'b1 || data_b_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL passthru_rd: regaddr_o=%0d wbi_o=%0d M_o=%b data_b_o=%h, expected 9 2 1 deadbeef",
                     regaddr_o, wbi_o, M_o, data_b_o);
        end
        checks++;
        if (out !== 32'h80000000 || zero !== 1'b0) begin
            failures++;
            $display("FAIL add_overflow: out=%h zero=%b, expected 80000000 0", out, zero);
        end
        control_Reg_DST = 1'b0; wbi = 2'd1; M = 1'b0;
        tick();
        checks++;
        if (regaddr_o !== 5'd5 || wbi_o !== 2'd1 || M_o !== 1'b0) begin
            failures++;
            $display("FAIL passthru_rt: regaddr_o=%0d wbi_o=%0d M_o=%b, expected 5 1 0", regaddr_o, wbi_o, M_o);
        end
    endtask

    task automatic test_rtype_misc();
        logic [31:0] a_v   [15] = '{32'h0000F0F0, 32'h0000F0F0, 32'h000000FF, 32'd0, 32'hFFFFFFFF,
                                    32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd4, 32'h00000024,
                                    32'd4, 32'd0, 32'd1, 32'hFFFFFFFF};
        logic [31:0] b_v   [15] = '{32'h0000FF00, 32'h00000F0F, 32'h0000000F, 32'd0, 32'd1,
                                    32'd1, 32'd1, 32'h80000000, 32'h80000000, 32'd1, 32'h80000000,
                                    32'hF0000000, 32'd1, 32'd1, 32'd1};
        logic [31:0] imm_v [15] = '{32'h24, 32'h25, 32'h26, 32'h27, 32'h2A,
                                    32'h2B, 32'h100, 32'h102, 32'h103, 32'h04, 32'h06,
                                    32'h07, 32'h23, 32'h3F, 32'h21};
        logic [31:0] exp_v [15] = '{32'h0000F000, 32'h0000FFFF, 32'h000000F0, 32'hFFFFFFFF, 32'd1,
                                    32'd0, 32'h00000010, 32'h08000000, 32'hF8000000, 32'h00000010, 32'h08000000,
                                    32'hFF000000, 32'hFFFFFFFF, 32'd0, 32'd0};
        for (int i = 0; i < 15; i++) begin
            drive_alu(a_v[i], b_v[i], imm_v[i], 4'b0010, 1'b1);
            tick();
            checks++;
            if (out !== exp_v[i] || zero !== (exp_v[i] == 32'd0)) begin
                failures++;
                $display("FAIL rtype_funct_%h: out=%h zero=%b expected %h %b",
                         imm_v[i][5:0], out, zero, exp_v[i], (exp_v[i] == 32'd0));
            end
        end
    endtask

    task automatic test_imm_compare();
        logic [31:0] a_v   [6] = '{32'd1, 32'd1, 32'hFFFFFFFE, 32'd5, 32'd1, 32'd10};
        logic [31:0] imm_v [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [3:0]  op_v  [6] = '{4'b1010, 4'b1011, 4'b1010, 4'b1001, 4'b0100, 4'b0011};
        logic        ub_v  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] exp_v [6] = '{32'd0, 32'd1, 32'd1, 32'd4, 32'd3, 32'd12};
        for (int i = 0; i < 6; i++) begin
            drive_alu(a_v[i], 32'd2, imm_v[i], op_v[i], ub_v[i]);
            tick();
            checks++;
            if (out !== exp_v[i]) begin
                failures++;
                $display("FAIL imm_cmp[%0d] oper=%b: out=%h expected %h", i, op_v[i], out, exp_v[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        drive_alu(32'd3, 32'd2, 32'd0, 4'b0000, 1'b1);
        npc = 32'd8; wbi = 2'd3; M = 1'b1;
        tick();
        checks++;
        if (out !== 32'd5 || wbi_o !== 2'd3) begin
            failures++;
            $display("FAIL pre_reset: out=%h wbi_o=%0d, expected 5 3", out, wbi_o);
        end
        reset = 1'b1;
        drive_alu(32'd7, 32'd2, 32'd0, 4'b0001, 1'b1);
        tick();
        checks++;
        if (out !== 32'd0 || zero !== 1'b0 || wbi_o !== 2'd0 || M_o !== 1'b0 || jump_address !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset: out=%h zero=%b wbi_o=%0d M_o=%b jump=%h, expected all 0",
                     out, zero, wbi_o, M_o, jump_address);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (out !== 32'd5 || zero !== 1'b0 || wbi_o !== 2'd3 || jump_address !== 32'd8) begin
            failures++;
            $display("FAIL post_reset: out=%h zero=%b wbi_o=%0d jump=%h, expected 5 0 3 8",
                     out, zero, wbi_o, jump_address);
        end
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_sub_addi();
        test_logical_imm();
        test_branch();
        test_passthrough();
        test_rtype_misc();
        test_imm_compare();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
